// File: rtl/osc_pkg.sv
// Shared types and constants for the oscilloscope capture path.
// Holds the trigger modes, the capture FSM states and a small sizing helper.
package osc_pkg;

    typedef enum logic [1:0] {
        RISE  = 2'd0,
        FALL  = 2'd1,
        AUTO  = 2'd2,
        FORCE = 2'd3
    } trig_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLDOFF   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_DONE      = 3'd4
    } cap_state_t;

    localparam int SAMPLE_W = 12;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adc_capture_ctrl_trigger_detect.sv
// Trigger detection: selects the trigger channel, keeps the previous sample and
// flags a level crossing, a forced trigger or an AUTO-mode timeout.
module trigger_detect
    import osc_pkg::*;
#(
    parameter int DATA_W       = SAMPLE_W,
    parameter int NUM_CH       = 2,
    parameter int AUTO_TIMEOUT = 4096,
    parameter int CNT_W        = 13,
    parameter int CH_W         = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     active,
    input  logic                     sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] sample,
    input  logic [CH_W-1:0]          trig_ch,
    input  logic [DATA_W-1:0]        trig_level,
    input  logic [1:0]               trig_mode,
    output logic                     trig_hit
);

    logic [DATA_W-1:0] ch_sample [NUM_CH];
    logic [DATA_W-1:0] cur_sample;
    logic [DATA_W-1:0] prev_reg;
    logic              has_prev_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic              rise_edge;
    logic              fall_edge;
    logic              timeout;
    trig_mode_t        mode;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_sample[gi] = sample[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Out-of-range channel numbers fall back to channel 0.
    always_comb begin
        cur_sample = ch_sample[0];
        for (int k = 1; k < NUM_CH; k++) begin
            if (trig_ch == CH_W'(k)) begin
                cur_sample = ch_sample[k];
            end
        end
    end

    assign mode      = trig_mode_t'(trig_mode);
    assign rise_edge = has_prev_reg && (prev_reg < trig_level) && (cur_sample >= trig_level);
    assign fall_edge = has_prev_reg && (prev_reg >= trig_level) && (cur_sample < trig_level);
    assign timeout   = (wait_cnt_reg >= CNT_W'(AUTO_TIMEOUT - 1));

    always_comb begin
        trig_hit = 1'b0;
        case (mode)
            RISE:    trig_hit = rise_edge;
            FALL:    trig_hit = fall_edge;
            AUTO:    trig_hit = rise_edge || timeout;
            FORCE:   trig_hit = 1'b1;
            default: trig_hit = 1'b0;
        endcase
    end

    // History and timeout restart every time the detector is re-armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg     <= '0;
            has_prev_reg <= 1'b0;
            wait_cnt_reg <= '0;
        end else if (!active) begin
            has_prev_reg <= 1'b0;
            wait_cnt_reg <= '0;
        end else if (sample_valid) begin
            prev_reg     <= cur_sample;
            has_prev_reg <= 1'b1;
            if (!timeout) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture controller: arms on enable, waits out holdoff, triggers, writes one
// fixed-length batch to the sample FIFO and reports ready/overflow status.
module adc_capture_ctrl
    import osc_pkg::*;
#(
    parameter int DATA_W       = SAMPLE_W,
    parameter int NUM_CH       = 2,
    parameter int BATCH_LEN    = 1024,
    parameter int HOLDOFF      = 16,
    parameter int AUTO_TIMEOUT = 4096,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int SW          = NUM_CH * DATA_W
) (
    input  logic              i_clk,
    input  logic              i_areset_n,
    input  logic              i_capture_enable,
    input  logic              i_mock_enable,
    input  logic [1:0]        i_trig_mode,
    input  logic [CH_W-1:0]   i_trig_ch,
    input  logic [DATA_W-1:0] i_trig_level,
    input  logic              i_clear_status,
    input  logic              i_adc_valid,
    input  logic [SW-1:0]     i_adc_data,
    input  logic              i_fifo_full,
    output logic              o_fifo_wr,
    output logic [SW-1:0]     o_fifo_data,
    output logic              o_busy,
    output logic              o_triggered,
    output logic              o_batch_ready,
    output logic              o_fifo_overflow
);

    localparam int CNT_W = $clog2(max3(BATCH_LEN, HOLDOFF, AUTO_TIMEOUT) + 1);

    cap_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              latch_cfg;
    logic              take_sample;
    logic              trig_hit;
    logic [1:0]        mode_reg;
    logic [CH_W-1:0]   ch_reg;
    logic [DATA_W-1:0] level_reg;
    logic [DATA_W-1:0] mock_cnt_reg;
    logic [SW-1:0]     mock_data;
    logic [SW-1:0]     cur_sample;
    logic              fifo_wr_reg;
    logic [SW-1:0]     fifo_data_reg;
    logic              batch_ready_reg;
    logic              overflow_reg;

    // Mock channels are the same sawtooth spread evenly across the code range.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mock
            assign mock_data[gi*DATA_W +: DATA_W] =
                mock_cnt_reg + DATA_W'(gi * ((2 ** DATA_W) / NUM_CH));
        end
    endgenerate

    assign cur_sample = i_mock_enable ? mock_data : i_adc_data;

    trigger_detect #(
        .DATA_W       (DATA_W),
        .NUM_CH       (NUM_CH),
        .AUTO_TIMEOUT (AUTO_TIMEOUT),
        .CNT_W        (CNT_W),
        .CH_W         (CH_W)
    ) u_trigger_detect (
        .clk          (i_clk),
        .rst_n        (i_areset_n),
        .active       (state_reg == ST_WAIT_TRIG),
        .sample_valid (i_adc_valid),
        .sample       (cur_sample),
        .trig_ch      (ch_reg),
        .trig_level   (level_reg),
        .trig_mode    (mode_reg),
        .trig_hit     (trig_hit)
    );

    // HOLDOFF is assumed >= 1; the triggering sample is batch sample 0.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        latch_cfg   = 1'b0;
        take_sample = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                state_next = ST_HOLDOFF;
                cnt_next   = '0;
                latch_cfg  = 1'b1;
            end
            ST_HOLDOFF: begin
                if (i_adc_valid) begin
                    if (cnt_reg == CNT_W'(HOLDOFF - 1)) begin
                        state_next = ST_WAIT_TRIG;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ST_WAIT_TRIG: begin
                if (i_adc_valid && trig_hit) begin
                    take_sample = 1'b1;
                    state_next  = ST_CAPTURE;
                    cnt_next    = CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (i_adc_valid) begin
                    take_sample = 1'b1;
                    if (cnt_reg == CNT_W'(BATCH_LEN - 1)) begin
                        state_next = ST_DONE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_HOLDOFF;
                cnt_next   = '0;
                latch_cfg  = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
        if (!i_capture_enable) begin
            state_next  = ST_IDLE;
            cnt_next    = '0;
            latch_cfg   = 1'b0;
            take_sample = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            mode_reg        <= '0;
            ch_reg          <= '0;
            level_reg       <= '0;
            mock_cnt_reg    <= '0;
            fifo_wr_reg     <= 1'b0;
            fifo_data_reg   <= '0;
            batch_ready_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            fifo_wr_reg     <= take_sample && !i_fifo_full;
            batch_ready_reg <= (state_reg == ST_DONE) && i_capture_enable;
            if (latch_cfg) begin
                mode_reg  <= i_trig_mode;
                ch_reg    <= i_trig_ch;
                level_reg <= i_trig_level;
            end
            if (i_adc_valid) begin
                mock_cnt_reg <= mock_cnt_reg + 1'b1;
            end
            if (take_sample && !i_fifo_full) begin
                fifo_data_reg <= cur_sample;
            end
            // A dropped sample outranks a same-cycle clear.
            if (take_sample && i_fifo_full) begin
                overflow_reg <= 1'b1;
            end else if (i_clear_status) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign o_fifo_wr       = fifo_wr_reg;
    assign o_fifo_data     = fifo_data_reg;
    assign o_busy          = (state_reg != ST_IDLE);
    assign o_triggered     = (state_reg == ST_CAPTURE);
    assign o_batch_ready   = batch_ready_reg;
    assign o_fifo_overflow = overflow_reg;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl with a short batch and holdoff.
// Stimulus pushes expected FIFO words; a negedge monitor pops and compares.
module tb_adc_capture_ctrl;
    import osc_pkg::*;

    localparam int DATA_W       = 12;
    localparam int NUM_CH       = 2;
    localparam int BATCH_LEN    = 8;
    localparam int HOLDOFF      = 2;
    localparam int AUTO_TIMEOUT = 5;

    logic        i_clk = 1'b0;
    logic        i_areset_n = 1'b0;
    logic        i_capture_enable = 1'b0;
    logic        i_mock_enable = 1'b0;
    logic [1:0]  i_trig_mode = 2'd0;
    logic [0:0]  i_trig_ch = 1'b0;
    logic [11:0] i_trig_level = '0;
    logic        i_clear_status = 1'b0;
    logic        i_adc_valid = 1'b0;
    logic [23:0] i_adc_data = '0;
    logic        i_fifo_full = 1'b0;
    logic        o_fifo_wr;
    logic [23:0] o_fifo_data;
    logic        o_busy;
    logic        o_triggered;
    logic        o_batch_ready;
    logic        o_fifo_overflow;

    always #5 i_clk = ~i_clk;

    adc_capture_ctrl #(
        .DATA_W       (DATA_W),
        .NUM_CH       (NUM_CH),
        .BATCH_LEN    (BATCH_LEN),
        .HOLDOFF      (HOLDOFF),
        .AUTO_TIMEOUT (AUTO_TIMEOUT)
    ) dut (
        .i_clk            (i_clk),
        .i_areset_n       (i_areset_n),
        .i_capture_enable (i_capture_enable),
        .i_mock_enable    (i_mock_enable),
        .i_trig_mode      (i_trig_mode),
        .i_trig_ch        (i_trig_ch),
        .i_trig_level     (i_trig_level),
        .i_clear_status   (i_clear_status),
        .i_adc_valid      (i_adc_valid),
        .i_adc_data       (i_adc_data),
        .i_fifo_full      (i_fifo_full),
        .o_fifo_wr        (o_fifo_wr),
        .o_fifo_data      (o_fifo_data),
        .o_busy           (o_busy),
        .o_triggered      (o_triggered),
        .o_batch_ready    (o_batch_ready),
        .o_fifo_overflow  (o_fifo_overflow)
    );

    logic [23:0] exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_wr_cyc = -10;
    int br_seen = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        logic [23:0] exp_word;
        if (o_fifo_wr) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got %h required no write", o_fifo_data);
            end else begin
                exp_word = exp_q.pop_front();
                check("fifo_data", o_fifo_data, exp_word);
            end
            last_wr_cyc = cyc;
        end
        if (o_batch_ready) begin
            check("batch_ready_gap", cyc - last_wr_cyc, 1);
            br_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sample(input logic [11:0] c0, input logic [11:0] c1, input logic full);
        i_adc_data  = {c1, c0};
        i_adc_valid = 1'b1;
        i_fifo_full = full;
        tick();
        i_adc_valid = 1'b0;
        i_fifo_full = 1'b0;
        tick();
    endtask

    task automatic arm(input logic [1:0] mode, input logic ch, input logic [11:0] lvl, input logic mock);
        i_trig_mode      = mode;
        i_trig_ch        = ch;
        i_trig_level     = lvl;
        i_mock_enable    = mock;
        i_capture_enable = 1'b1;
        tick();
        check("busy_after_arm", o_busy, 1);
    endtask

    task automatic disarm();
        i_capture_enable = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [11:0] r2 [11] = '{90, 95, 99, 100, 105, 110, 115, 120, 125, 130, 135};
        logic [11:0] r3 [11] = '{10, 10, 60, 40, 30, 20, 10, 5, 4, 3, 2};

        tick();
        tick();
        check("rst_fifo_wr", o_fifo_wr, 0);
        check("rst_busy", o_busy, 0);
        check("rst_triggered", o_triggered, 0);
        check("rst_batch_ready", o_batch_ready, 0);
        check("rst_overflow", o_fifo_overflow, 0);
        i_areset_n = 1'b1;
        tick();

        // 1: FORCE on mock sawtooth; holdoff eats codes 0,1.
        arm(FORCE, 1'b0, 12'd0, 1'b1);
        for (int i = 0; i < 8; i++) exp_q.push_back({12'(2050 + i), 12'(2 + i)});
        for (int i = 0; i < 10; i++) sample(12'd0, 12'd0, 1'b0);
        tick();
        check("t1_batches", br_seen, 1);
        disarm();

        // 2: RISE on ch1 at 100; level change after arm must be ignored.
        arm(RISE, 1'b1, 12'd100, 1'b0);
        i_trig_level = 12'd92;
        sample(12'd0, 12'd0, 1'b0);
        sample(12'd0, 12'd0, 1'b0);
        for (int i = 3; i < 11; i++) exp_q.push_back({r2[i], 12'(i)});
        for (int i = 0; i < 11; i++) begin
            sample(12'(i), r2[i], 1'b0);
            if (i == 2) check("t2_not_triggered", o_triggered, 0);
            if (i == 3) check("t2_triggered", o_triggered, 1);
        end
        tick();
        check("t2_batches", br_seen, 2);
        disarm();

        // 3: FALL on ch0 at 50; stale holdoff data must not count as prev.
        arm(FALL, 1'b0, 12'd50, 1'b0);
        sample(12'd200, 12'd0, 1'b0);
        sample(12'd200, 12'd0, 1'b0);
        for (int i = 3; i < 11; i++) exp_q.push_back({12'(i), r3[i]});
        for (int i = 0; i < 11; i++) begin
            sample(r3[i], 12'(i), 1'b0);
            if (i == 0) check("t3_no_first_trig", o_triggered, 0);
        end
        tick();
        check("t3_batches", br_seen, 3);
        disarm();

        // 4: AUTO with a flat input times out on the 5th waiting sample.
        arm(AUTO, 1'b0, 12'd100, 1'b0);
        sample(12'd7, 12'd0, 1'b0);
        sample(12'd7, 12'd0, 1'b0);
        for (int i = 4; i < 12; i++) exp_q.push_back({12'(i), 12'd7});
        for (int i = 0; i < 12; i++) begin
            sample(12'd7, 12'(i), 1'b0);
            if (i == 3) check("t4_not_triggered", o_triggered, 0);
            if (i == 4) check("t4_triggered", o_triggered, 1);
        end
        tick();
        check("t4_batches", br_seen, 4);
        disarm();

        // 5: FIFO full on batch samples 3 and 4.
        arm(FORCE, 1'b0, 12'd0, 1'b0);
        check("t5_ovf_before", o_fifo_overflow, 0);
        sample(12'd0, 12'd0, 1'b0);
        sample(12'd0, 12'd0, 1'b0);
        for (int i = 0; i < 8; i++) if (i != 3 && i != 4) exp_q.push_back({12'd0, 12'(300 + i)});
        for (int i = 0; i < 8; i++) sample(12'(300 + i), 12'd0, (i == 3) || (i == 4));
        check("t5_ovf_set", o_fifo_overflow, 1);
        tick();
        check("t5_batches", br_seen, 5);
        disarm();
        check("t5_ovf_sticky", o_fifo_overflow, 1);
        i_clear_status = 1'b1;
        tick();
        i_clear_status = 1'b0;
        check("t5_ovf_cleared", o_fifo_overflow, 0);

        // 6: enable dropped mid-capture, then async reset mid-capture.
        arm(FORCE, 1'b0, 12'd0, 1'b0);
        sample(12'd0, 12'd0, 1'b0);
        sample(12'd0, 12'd0, 1'b0);
        for (int i = 0; i < 3; i++) exp_q.push_back({12'd0, 12'(400 + i)});
        for (int i = 0; i < 3; i++) sample(12'(400 + i), 12'd0, 1'b0);
        check("t6_triggered", o_triggered, 1);
        i_capture_enable = 1'b0;
        tick();
        check("t6_busy_dropped", o_busy, 0);
        check("t6_triggered_dropped", o_triggered, 0);
        for (int i = 0; i < 3; i++) sample(12'(410 + i), 12'd0, 1'b0);
        tick();
        check("t6_no_batch_ready", br_seen, 5);

        arm(FORCE, 1'b0, 12'd0, 1'b0);
        sample(12'd0, 12'd0, 1'b0);
        sample(12'd0, 12'd0, 1'b0);
        exp_q.push_back({12'd0, 12'd500});
        sample(12'd500, 12'd0, 1'b0);
        i_adc_data  = {12'd0, 12'd501};
        i_adc_valid = 1'b1;
        tick();
        i_adc_valid = 1'b0;
        check("t6_wr_before_reset", o_fifo_wr, 1);
        #1 i_areset_n = 1'b0;
        #1;
        check("t6_rst_fifo_wr", o_fifo_wr, 0);
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_triggered", o_triggered, 0);
        check("t6_rst_batch_ready", o_batch_ready, 0);
        check("t6_rst_overflow", o_fifo_overflow, 0);
        i_capture_enable = 1'b0;
        tick();
        i_areset_n = 1'b1;
        tick();
        tick();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_batches", br_seen, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
